// File: rtl/apb_reg_slave_if.sv
// APB bus bundle between a requester and the apb_reg_slave completer.
interface apb_reg_slave_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_reg_slave.sv
// APB completer: CTRL/DATA0/DATA1 RW, SUM/STATUS RO, programmable wait states.
// Define APB_REG_SLAVE_PSLVERR_EN to drive pslverr and enable the ERR_CNT field.
module apb_reg_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  apb_reg_slave_if.slave        apb,
  output logic [31:0]           ctrl_o,
  output logic [31:0]           sum_o
);

  localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_e;

  state_e      state_q;
  logic [3:0]  wait_cnt_q;

  logic [31:0] ctrl_q,  ctrl_d;
  logic [31:0] data0_q, data0_d;
  logic [31:0] data1_q, data1_d;
  logic [15:0] xfer_cnt_q, xfer_cnt_d;
  logic [7:0]  err_cnt;

  logic [32:0] sum_full;
  logic [31:0] status;
  logic [31:0] rdata;
  logic [2:0]  offset;
  logic        hit;
  logic        err;
  logic        pready;

  // Gating with ST_ACCESS keeps pready low while reset holds the FSM idle.
  assign pready = (state_q == ST_ACCESS) && apb.psel && apb.penable &&
                  (wait_cnt_q == WAIT_N);

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          wait_cnt_q <= '0;
          if (apb.psel && !apb.penable) state_q <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (!apb.psel || pready) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
          end else if (apb.penable && (wait_cnt_q < WAIT_N)) begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  assign sum_full = {1'b0, data0_q} + {1'b0, data1_q};
  assign status   = {xfer_cnt_q, err_cnt, 7'd0, sum_full[32]};

  assign hit    = (apb.paddr[31:5] == BASE_ADDR[31:5]) && (apb.paddr[1:0] == 2'b00);
  assign offset = apb.paddr[4:2];

  always_comb begin
    err   = 1'b0;
    rdata = '0;
    if (!hit) begin
      err = 1'b1;
    end else begin
      case (offset)
        3'd0: rdata = ctrl_q;
        3'd1: rdata = data0_q;
        3'd2: rdata = data1_q;
        3'd3: begin
          rdata = sum_full[31:0];
          err   = apb.pwrite;
        end
        3'd4: begin
          rdata = status;
          err   = apb.pwrite;
        end
        default: err = 1'b1;
      endcase
    end
  end

  assign apb.pready = pready;
  assign apb.prdata = (pready && !apb.pwrite && !err) ? rdata : '0;

  always_comb begin
    ctrl_d     = ctrl_q;
    data0_d    = data0_q;
    data1_d    = data1_q;
    xfer_cnt_d = xfer_cnt_q;
    if (pready && !err) begin
      xfer_cnt_d = xfer_cnt_q + 16'd1;
      if (apb.pwrite) begin
        case (offset)
          3'd0:    ctrl_d  = apb.pwdata;
          3'd1:    data0_d = apb.pwdata;
          3'd2:    data1_d = apb.pwdata;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      ctrl_q     <= '0;
      data0_q    <= '0;
      data1_q    <= '0;
      xfer_cnt_q <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

`ifdef APB_REG_SLAVE_PSLVERR_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      err_cnt_q <= '0;
    end else if (pready && err && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt     = err_cnt_q;
  assign apb.pslverr = pready && err;
`else
  assign err_cnt     = '0;
  assign apb.pslverr = 1'b0;
`endif

  assign ctrl_o = ctrl_q;
  assign sum_o  = sum_full[31:0];

endmodule

// File: tb/tb_apb_reg_slave.sv
// Scoreboard bench: two completers (0 and 3 wait states) checked against a register-map model.
module tb_apb_reg_slave;

  localparam logic [31:0] BASE = 32'h4000_0020;
  localparam int unsigned W1   = 3;
`ifdef APB_REG_SLAVE_PSLVERR_EN
  localparam bit PSLVERR_EN = 1'b1;
`else
  localparam bit PSLVERR_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;

  logic        psel[2];
  logic        penable[2];
  logic        pwrite[2];
  logic [31:0] paddr[2];
  logic [31:0] pwdata[2];
  logic [31:0] prdata[2];
  logic        pready[2];
  logic        pslverr[2];
  logic [31:0] ctrl[2];
  logic [31:0] sum[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    apb_reg_slave_if bus ();
    assign bus.psel    = psel[g];
    assign bus.penable = penable[g];
    assign bus.pwrite  = pwrite[g];
    assign bus.paddr   = paddr[g];
    assign bus.pwdata  = pwdata[g];
    assign prdata[g]   = bus.prdata;
    assign pready[g]   = bus.pready;
    assign pslverr[g]  = bus.pslverr;

    apb_reg_slave #(
      .BASE_ADDR   (BASE),
      .WAIT_CYCLES ((g == 0) ? 0 : W1)
    ) u_dut (
      .pclk     (clk),
      .preset_n (rst_n),
      .apb      (bus.slave),
      .ctrl_o   (ctrl[g]),
      .sum_o    (sum[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference model: architectural register contents and counters.
  logic [31:0] m_reg[3];
  int unsigned m_xfer;
  int unsigned m_err;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) m_reg[i] = '0;
    m_xfer = 0;
    m_err  = 0;
  endfunction

  function automatic logic [31:0] model_sum();
    longint unsigned s = longint'(m_reg[1]) + longint'(m_reg[2]);
    return 32'(s % 64'h1_0000_0000);
  endfunction

  function automatic void model_access(input bit wr, input logic [31:0] a,
                                       input logic [31:0] wd,
                                       output bit e, output logic [31:0] rd);
    int unsigned     ai = a;
    int unsigned     off = (ai % 32) / 4;
    bit              hit = ((ai / 32) == (BASE / 32)) && ((ai % 4) == 0);
    longint unsigned s = longint'(m_reg[1]) + longint'(m_reg[2]);
    int unsigned     carry = (s >= 64'h1_0000_0000) ? 1 : 0;
    e  = !hit || (off > 4) || (wr && off >= 3);
    rd = '0;
    if (!e) begin
      if (wr) m_reg[off] = wd;
      else if (off <= 2) rd = m_reg[off];
      else if (off == 3) rd = model_sum();
      else rd = 32'((m_xfer % 65536) * 65536 + m_err * 256 + carry);
      m_xfer++;
    end else if (PSLVERR_EN && m_err < 255) begin
      m_err++;
    end
  endfunction

  typedef struct {
    int          d;
    bit          err;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (pready[d] === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pready: dut %0d completed with %0d pending expected", d, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_dut", 32'(d), 32'(e.d));
          chk("pslverr", {31'd0, pslverr[d]}, {31'd0, e.err});
          chk("prdata", prdata[d], e.rd);
        end
      end
    end
  end

  function automatic int unsigned waits(int d);
    return (d == 0) ? 0 : W1;
  endfunction

  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd);
    bit          e;
    logic [31:0] rd;
    int          acc;
    model_access(wr, a, wd, e, rd);
    sb.push_back('{d, e && PSLVERR_EN, rd});
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    acc = 1;
    #1;
    while (pready[d] !== 1'b1 && acc < 40) begin
      @(posedge clk); #2;
      acc++;
    end
    chk("latency", 32'(acc), 32'(waits(d) + 1));
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
    chk("ctrl_o", ctrl[d], m_reg[0]);
    chk("sum_o", sum[d], model_sum());
  endtask

  // Setup plus k access cycles that must not complete; caller then aborts or resets.
  task automatic start_noresp(input int d, input bit wr, input logic [31:0] a,
                              input logic [31:0] wd, input int k);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
    #1;
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      penable[d] = 1'b1;
      #1;
      chk("no_pready", {31'd0, pready[d]}, 32'd0);
    end
  endtask

  task automatic check_zero_outputs(input int d);
    chk("rst_pready", {31'd0, pready[d]}, 32'd0);
    chk("rst_prdata", prdata[d], 32'd0);
    chk("rst_pslverr", {31'd0, pslverr[d]}, 32'd0);
    chk("rst_ctrl_o", ctrl[d], 32'd0);
    chk("rst_sum_o", sum[d], 32'd0);
  endtask

  task automatic run(input int d);
    int k;
    k = (waits(d) > 0) ? 2 : 0;

    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_zero_outputs(d);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    xfer(d, 1'b0, BASE + 32'h10, '0);
    xfer(d, 1'b1, BASE + 32'h04, 32'hFFFF_FFFF);
    xfer(d, 1'b1, BASE + 32'h08, 32'h0000_0002);
    xfer(d, 1'b0, BASE + 32'h0C, '0);
    xfer(d, 1'b0, BASE + 32'h10, '0);

    xfer(d, 1'b1, BASE + 32'h00, 32'hA5A5_0001);
    xfer(d, 1'b0, BASE + 32'h00, '0);

    xfer(d, 1'b1, BASE + 32'h0C, 32'h0000_1234);
    xfer(d, 1'b1, BASE + 32'h18, 32'h0000_1234);
    xfer(d, 1'b0, BASE + 32'h0C, '0);
    xfer(d, 1'b0, BASE + 32'h10, '0);
    for (int i = 0; i < 256; i++) begin
      case (i % 4)
        0:       xfer(d, 1'b0, BASE + 32'h1C, '0);
        1:       xfer(d, 1'b1, BASE + 32'h10, 32'(i));
        2:       xfer(d, 1'b0, BASE + 32'h02, '0);
        default: xfer(d, 1'b1, BASE + 32'h20, 32'(i));
      endcase
    end
    xfer(d, 1'b0, BASE + 32'h10, '0);

    start_noresp(d, 1'b1, BASE + 32'h04, 32'h0000_0055, k);
    psel[d] = 1'b0; penable[d] = 1'b0;
    @(posedge clk); #1;
    xfer(d, 1'b0, BASE + 32'h04, '0);
    xfer(d, 1'b0, BASE + 32'h10, '0);

    for (int i = 0; i < 40; i++) begin
      int unsigned r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if (r < 8)       a = BASE + 32'(r * 4);
      else if (r == 8) a = BASE + 32'($urandom_range(1, 3));
      else             a = BASE ^ 32'h0100_0000;
      xfer(d, 1'($urandom_range(0, 1)), a, $urandom());
    end
    xfer(d, 1'b1, BASE + 32'h00, 32'h0BAD_F00D);
    xfer(d, 1'b0, BASE + 32'h10, '0);

    start_noresp(d, 1'b1, BASE + 32'h00, 32'h1111_2222, k);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero_outputs(d);
    psel[d] = 1'b0; penable[d] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(d, 1'b1, BASE + 32'h00, 32'hC0DE_0042);
    xfer(d, 1'b0, BASE + 32'h00, '0);
    xfer(d, 1'b0, BASE + 32'h10, '0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0;
    end
    rst_n = 1'b0;
    run(0);
    run(1);
    @(posedge clk); #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d pending", sb.size());
    $fatal(1, "watchdog");
  end

endmodule
